// File: rtl/z_buffer_stream_reader.sv
// Read side of the whitened-Z sample buffer: sweeps addresses 0..DEPTH-1 per epoch and
// streams 4-lane samples on valid/ready. Define ZRD_CHECKSUM_EN to add the chk_out port.
module z_buffer_stream_reader #(
    parameter int DW      = 26,
    parameter int DEPTH   = 128,
    parameter int AW      = 7,
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [EPOCH_W-1:0] num_epochs,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [AW-1:0]      mem_addr,
    input  logic [DW-1:0]      mem_q1,
    input  logic [DW-1:0]      mem_q2,
    input  logic [DW-1:0]      mem_q3,
    input  logic [DW-1:0]      mem_q4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_z1,
    output logic [DW-1:0]      out_z2,
    output logic [DW-1:0]      out_z3,
    output logic [DW-1:0]      out_z4,
    output logic [AW-1:0]      out_idx,
    output logic               out_last,
    output logic               out_final
`ifdef ZRD_CHECKSUM_EN
    ,
    output logic [DW-1:0]      chk_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0][DW-1:0] z;
        logic [AW-1:0]      idx;
        logic               last;
        logic               fin;
    } entry_t;

    state_t state_q, state_next;

    logic [EPOCH_W-1:0] num_epochs_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic [AW-1:0]      addr_q;

    logic               inflight_q;
    logic [AW-1:0]      inflight_idx_q;
    logic               inflight_last_q;
    logic               inflight_fin_q;

    entry_t             fifo_q [2];
    logic [1:0]         fifo_count_q;

    logic               start_ok;
    logic               rd_en;
    logic               push;
    logic               pop;
    logic               addr_at_end;
    logic               last_read;
    logic [1:0]         count_after_pop;
    logic [1:0]         credit_used;
    entry_t             push_entry;

    assign start_ok        = (state_q == S_IDLE) && start;
    assign out_valid       = (fifo_count_q != 2'd0);
    assign pop             = out_valid && out_ready;
    assign push            = inflight_q;
    assign count_after_pop = fifo_count_q - {1'b0, pop};
    // Occupancy after this cycle's pop plus the read already in flight bounds the FIFO at 2.
    assign credit_used     = count_after_pop + {1'b0, inflight_q};
    assign addr_at_end     = (addr_q == AW'(DEPTH - 1));
    assign last_read       = addr_at_end && (epoch_q == num_epochs_q - EPOCH_W'(1));

    always_comb begin
        push_entry      = '0;
        push_entry.z    = {mem_q4, mem_q3, mem_q2, mem_q1};
        push_entry.idx  = inflight_idx_q;
        push_entry.last = inflight_last_q;
        push_entry.fin  = inflight_fin_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_epochs == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = (credit_used < 2'd2);
                if (rd_en && last_read) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (count_after_pop == 2'd0 && !inflight_q) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_epochs_q <= '0;
            epoch_q      <= '0;
            addr_q       <= '0;
        end else if (start_ok) begin
            num_epochs_q <= num_epochs;
            epoch_q      <= '0;
            addr_q       <= '0;
        end else if (rd_en) begin
            if (addr_at_end) begin
                addr_q  <= '0;
                epoch_q <= epoch_q + EPOCH_W'(1);
            end else begin
                addr_q <= addr_q + AW'(1);
            end
        end
    end

    // Tags travel alongside the read so they line up with mem_q one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_idx_q  <= '0;
            inflight_last_q <= 1'b0;
            inflight_fin_q  <= 1'b0;
        end else begin
            inflight_q      <= rd_en;
            inflight_idx_q  <= addr_q;
            inflight_last_q <= addr_at_end;
            inflight_fin_q  <= last_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two FIFO slots are reset because they drive out_* directly and must read 0 after reset.
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            fifo_count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    fifo_q[fifo_count_q[0]] <= push_entry;
                    fifo_count_q            <= fifo_count_q + 2'd1;
                end
                2'b01: begin
                    fifo_q[0]    <= fifo_q[1];
                    fifo_count_q <= fifo_count_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_count_q == 2'd2) begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= push_entry;
                    end else begin
                        fifo_q[0] <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en = rd_en;
    assign mem_addr  = addr_q;
    assign out_z1    = fifo_q[0].z[0];
    assign out_z2    = fifo_q[0].z[1];
    assign out_z3    = fifo_q[0].z[2];
    assign out_z4    = fifo_q[0].z[3];
    assign out_idx   = fifo_q[0].idx;
    assign out_last  = fifo_q[0].last;
    assign out_final = fifo_q[0].fin;

`ifdef ZRD_CHECKSUM_EN
    logic [DW-1:0] chk_q;

    // A start can only be accepted with the FIFO empty, so clear and accumulate never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (start_ok) begin
            chk_q <= '0;
        end else if (pop) begin
            chk_q <= chk_q ^ out_z1 ^ out_z2 ^ out_z3 ^ out_z4;
        end
    end

    assign chk_out = chk_q;
`endif

endmodule

// File: tb/tb_z_buffer_stream_reader.sv
// Self-checking bench for z_buffer_stream_reader: random data/backpressure against a
// queue-based model of the expected sample sequence, timing and reset checks.
module tb_z_buffer_stream_reader;

    localparam int DW      = 26;
    localparam int DEPTH   = 128;
    localparam int AW      = 7;
    localparam int EPOCH_W = 8;

    typedef struct packed {
        logic [3:0][DW-1:0] z;
        logic [AW-1:0]      idx;
        logic               last;
        logic               fin;
    } sample_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [EPOCH_W-1:0] num_epochs;
    logic               busy;
    logic               done;
    logic               mem_rd_en;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_q1, mem_q2, mem_q3, mem_q4;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_z1, out_z2, out_z3, out_z4;
    logic [AW-1:0]      out_idx;
    logic               out_last;
    logic               out_final;
`ifdef ZRD_CHECKSUM_EN
    logic [DW-1:0]      chk_out;
`endif

    z_buffer_stream_reader #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .EPOCH_W(EPOCH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_epochs(num_epochs),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_q1(mem_q1), .mem_q2(mem_q2), .mem_q3(mem_q3), .mem_q4(mem_q4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z1(out_z1), .out_z2(out_z2), .out_z3(out_z3), .out_z4(out_z4),
        .out_idx(out_idx), .out_last(out_last), .out_final(out_final)
`ifdef ZRD_CHECKSUM_EN
        , .chk_out(chk_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model with one-cycle read latency.
    logic [DW-1:0] mem [4][DEPTH];
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_q1 <= mem[0][mem_addr];
            mem_q2 <= mem[1][mem_addr];
            mem_q3 <= mem[2][mem_addr];
            mem_q4 <= mem[3][mem_addr];
        end
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    sample_t       exp_q[$];
    logic [DW-1:0] exp_chk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // mode 0: lane k = 1000*k+addr; 1: random; 2: {addr,0,0,0}; 3: {addr+1,0,0,0}
    task automatic fill_mem(input int mode);
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < 4; k++) begin
                case (mode)
                    0:       mem[k][a] = DW'(1000 * (k + 1) + a);
                    1:       mem[k][a] = DW'($urandom);
                    2:       mem[k][a] = (k == 0) ? DW'(a) : '0;
                    default: mem[k][a] = (k == 0) ? DW'(a + 1) : '0;
                endcase
            end
        end
    endtask

    task automatic build_expected(input int e);
        sample_t s;
        exp_q.delete();
        exp_chk = '0;
        for (int ep = 0; ep < e; ep++) begin
            for (int a = 0; a < DEPTH; a++) begin
                for (int k = 0; k < 4; k++) begin
                    s.z[k] = mem[k][a];
                    exp_chk = exp_chk ^ mem[k][a];
                end
                s.idx  = AW'(a);
                s.last = (a == DEPTH - 1);
                s.fin  = (a == DEPTH - 1) && (ep == e - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    function automatic sample_t observed();
        sample_t s;
        s.z    = {out_z4, out_z3, out_z2, out_z1};
        s.idx  = out_idx;
        s.last = out_last;
        s.fin  = out_final;
        return s;
    endfunction

    task automatic check_reset_outs();
        check("rst_busy", 128'(busy), 0);
        check("rst_done", 128'(done), 0);
        check("rst_rd_en", 128'(mem_rd_en), 0);
        check("rst_addr", 128'(mem_addr), 0);
        check("rst_valid", 128'(out_valid), 0);
        check("rst_sample", 128'(observed()), 0);
`ifdef ZRD_CHECKSUM_EN
        check("rst_chk", 128'(chk_out), 0);
`endif
    endtask

    // mode 0: ready held 1; mode 1: random ready with a 10-cycle stall after 60 samples.
    task automatic run(input int e, input int mode, input int abort_at, input bit extra_start);
        int      s_cyc, first_valid, done_cyc, done_cnt, busy_cnt, hs, issued, max_out;
        int      stall_left, valid_cnt;
        bit      prev_stall, stall_used, finished;
        sample_t held, got, want;

        build_expected(e);
        start      = 1'b1;
        num_epochs = EPOCH_W'(e);
        out_ready  = 1'b1;
        tick();
        s_cyc      = cyc;
        start      = 1'b0;
        num_epochs = EPOCH_W'($urandom);
        first_valid = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; hs = 0;
        issued = 0; max_out = 0; stall_left = 0; valid_cnt = 0;
        prev_stall = 0; stall_used = 0; finished = 0; held = '0;

        for (int i = 0; i < e * DEPTH * 8 + 50; i++) begin
            if (extra_start && cyc == s_cyc + 100) begin
                start      = 1'b1;
                num_epochs = EPOCH_W'(5);
            end else begin
                start = 1'b0;
            end
            if (mode == 1) begin
                if (!stall_used && hs >= 60) begin
                    stall_used = 1;
                    stall_left = 10;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                out_ready = 1'b1;
            end
            if (abort_at >= 0 && hs == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outs();
                tick();
                rst_n = 1'b1;
                exp_q.delete();
                tick();
                return;
            end

            @(negedge clk);
            got = observed();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (mem_rd_en) issued++;
            if (prev_stall) begin
                check("stall_valid", 128'(out_valid), 1);
                check("stall_hold", 128'(got), 128'(held));
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (out_valid && out_ready) begin
                check("sample_expected", 128'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("sample", 128'(got), 128'(want));
                end
                hs++;
            end
            prev_stall = out_valid && !out_ready;
            held       = got;
            if (issued - hs > max_out) max_out = issued - hs;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("done_width", 128'(done), 0);
                check("busy_after_done", 128'(busy), 0);
                finished = 1;
                break;
            end
            tick();
        end

        check("run_finished", 128'(finished), 1);
        check("hs_count", 128'(hs), 128'(e * DEPTH));
        check("queue_left", 128'(exp_q.size()), 0);
        check("max_outstanding_over_2", 128'(max_out > 2), 0);
        check("done_pulses", 128'(done_cnt), 1);
        if (e == 0) begin
            check("no_valid", 128'(valid_cnt), 0);
        end else begin
            check("first_valid_lat", 128'(first_valid - s_cyc), 2);
        end
        if (mode == 0) begin
            check("done_time", 128'(done_cyc - s_cyc), (e == 0) ? 128'(0) : 128'(e * DEPTH + 2));
            check("busy_cycles", 128'(busy_cnt), (e == 0) ? 128'(0) : 128'(e * DEPTH + 2));
        end
`ifdef ZRD_CHECKSUM_EN
        check("chk", 128'(chk_out), 128'(exp_chk));
        tick();
        check("chk_hold", 128'(chk_out), 128'(exp_chk));
`endif
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        num_epochs = '0;
        out_ready  = 1'b1;
        fill_mem(0);
        tick();
        tick();
        check_reset_outs();
        rst_n = 1'b1;
        tick();

        fill_mem(0);
        run(1, 0, -1, 1'b0);

        fill_mem(1);
        run(3, 0, -1, 1'b1);

        fill_mem(1);
        run(2, 1, -1, 1'b0);

        run(0, 0, -1, 1'b0);

        fill_mem(1);
        run(2, 0, 50, 1'b0);
        fill_mem(0);
        run(1, 0, -1, 1'b0);

`ifdef ZRD_CHECKSUM_EN
        fill_mem(2);
        run(1, 0, -1, 1'b0);
        check("chk_xor_0_127", 128'(chk_out), 0);
        fill_mem(3);
        run(1, 0, -1, 1'b0);
        check("chk_xor_1_128", 128'(chk_out), 128);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
